fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_if.sv | 25 ++
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bus: stall/redirect control in, program-memory address out, instruction register out.
interface fetch_if #(
   parameter int PC_WIDTH = 10
);
   logic                stall;
   logic                redirect;
   logic [31:0]         redirect_target;
   logic [31:0]         ins_in;
   logic [PC_WIDTH-1:0] pc_out;
   logic [31:0]         ir_out;
   logic [PC_WIDTH-1:0] ir_pc;
   logic                ir_valid;
   logic                halted;
   logic                misalign_err;

   modport master (
      input  stall, redirect, redirect_target, ins_in,
      output pc_out, ir_out, ir_pc, ir_valid, halted, misalign_err
   );

   modport slave (
      output stall, redirect, redirect_target, ins_in,
      input  pc_out, ir_out, ir_pc, ir_valid, halted, misalign_err
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: word-index PC, one-cycle instruction register, BOOT/FETCH/HALT control.
// Optional FETCH_HALT_DETECT_EN: an all-zero instruction word halts the fetch stage.
module fetch_unit #(
   parameter int                  PC_WIDTH = 10,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input logic     clk,
   input logic     rst,
   fetch_if.master bus
);
   typedef enum logic [1:0] {BOOT, FETCH, HALT} state_t;

   state_t              state, state_next;
   logic                in_fetch;
   logic                misaligned;
   logic                do_redirect;
   logic                do_trap;
   logic                zero_halt;
   logic                do_fetch;
   logic                hold_valid;
   logic [PC_WIDTH-1:0] pc;
   logic [PC_WIDTH-1:0] target_pc;
   logic [31:0]         ir;
   logic [PC_WIDTH-1:0] ir_pc;
   logic                ir_valid;
   logic                misalign_err;
   logic                target_unused;

   // Targets are byte addresses; bits above the PC range are dropped on purpose.
   assign target_pc     = bus.redirect_target[PC_WIDTH+1:2];
   assign target_unused = ^bus.redirect_target[31:PC_WIDTH+2];

   assign in_fetch    = (state == FETCH);
   assign misaligned  = (bus.redirect_target[1:0] != 2'b00);
   assign do_redirect = in_fetch & bus.redirect & ~misaligned;
   assign do_trap     = in_fetch & bus.redirect & misaligned;
`ifdef FETCH_HALT_DETECT_EN
   assign zero_halt   = in_fetch & ~bus.redirect & ~bus.stall & (bus.ins_in == 32'h0);
`else
   assign zero_halt   = 1'b0;
`endif
   assign do_fetch    = in_fetch & ~bus.redirect & ~bus.stall & ~zero_halt;
   assign hold_valid  = in_fetch & ~bus.redirect & bus.stall & ir_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= BOOT;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         BOOT:    state_next = FETCH;
         FETCH:   if (do_trap || zero_halt) state_next = HALT;
         HALT:    state_next = HALT;
         default: state_next = BOOT;
      endcase
   end

   always_comb begin
      bus.halted = (state == HALT);
   end

   // Redirect outranks stall; a flushed or halted cycle always drops ir_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc           <= RESET_PC;
         ir           <= '0;
         ir_pc        <= '0;
         ir_valid     <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         if (do_redirect) begin
            pc <= target_pc;
         end else if (do_fetch) begin
            pc <= pc + PC_WIDTH'(1);
         end
         if (do_fetch) begin
            ir    <= bus.ins_in;
            ir_pc <= pc;
         end
         ir_valid <= do_fetch | hold_valid;
         if (do_trap) begin
            misalign_err <= 1'b1;
         end
      end
   end

   assign bus.pc_out       = pc;
   assign bus.ir_out       = ir;
   assign bus.ir_pc        = ir_pc;
   assign bus.ir_valid     = ir_valid;
   assign bus.misalign_err = misalign_err;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential fetch, stall, redirect, wrap, misalign trap, async reset.
module tb_fetch_unit;
   logic clk;
   logic rst;
   logic [31:0] mem [1024];
   int n_assert;
   int n_fail;

   fetch_if #(.PC_WIDTH(10)) bus ();

   fetch_unit #(.PC_WIDTH(10), .RESET_PC(10'd0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Program memory reads combinationally and outputs zero while in reset.
   assign bus.ins_in = rst ? 32'h0 : mem[bus.pc_out];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_pc"},  32'(bus.pc_out), 32'h0);
      check({tag, "_ir"},  bus.ir_out, 32'h0);
      check({tag, "_irpc"}, 32'(bus.ir_pc), 32'h0);
      check({tag, "_vld"}, 32'(bus.ir_valid), 32'h0);
      check({tag, "_hlt"}, 32'(bus.halted), 32'h0);
      check({tag, "_mis"}, 32'(bus.misalign_err), 32'h0);
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | 32'(i);
      mem[0] = 32'h0010_0093;
      mem[1] = 32'h0020_0113;
      rst                 = 1'b0;
      bus.stall           = 1'b0;
      bus.redirect        = 1'b0;
      bus.redirect_target = 32'h0;

      // Asynchronous reset, observed before any clock edge.
      #2 rst = 1'b1;
      #1 check_reset_state("rst_async");
      tick();
      tick();
      rst = 1'b0;

      // BOOT cycle: no instruction yet.
      tick();
      check("boot_vld", 32'(bus.ir_valid), 32'h0);
      check("boot_pc", 32'(bus.pc_out), 32'h0);
      tick();
      check("f0_ir", bus.ir_out, 32'h0010_0093);
      check("f0_irpc", 32'(bus.ir_pc), 32'h0);
      check("f0_vld", 32'(bus.ir_valid), 32'h1);
      check("f0_pc", 32'(bus.pc_out), 32'h1);
      tick();
      check("f1_ir", bus.ir_out, 32'h0020_0113);
      check("f1_irpc", 32'(bus.ir_pc), 32'h1);
      check("f1_vld", 32'(bus.ir_valid), 32'h1);
      tick();
      tick();
      tick();
      check("f4_pc", 32'(bus.pc_out), 32'h5);
      check("f4_ir", bus.ir_out, 32'hA000_0004);

      // Stall for three cycles at pc 5.
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_pc", 32'(bus.pc_out), 32'h5);
         check("stall_ir", bus.ir_out, 32'hA000_0004);
         check("stall_irpc", 32'(bus.ir_pc), 32'h4);
         check("stall_vld", 32'(bus.ir_valid), 32'h1);
      end
      bus.stall = 1'b0;
      tick();
      check("unstall_pc", 32'(bus.pc_out), 32'h6);
      check("unstall_ir", bus.ir_out, 32'hA000_0005);

      // Redirect to byte 0x20 while stalled: redirect wins.
      bus.redirect        = 1'b1;
      bus.redirect_target = 32'h20;
      bus.stall           = 1'b1;
      tick();
      check("redir_pc", 32'(bus.pc_out), 32'h8);
      check("redir_vld", 32'(bus.ir_valid), 32'h0);
      bus.redirect = 1'b0;
      bus.stall    = 1'b0;
      tick();
      check("redir_irpc", 32'(bus.ir_pc), 32'h8);
      check("redir_ir", bus.ir_out, 32'hA000_0008);
      check("redir_vld2", 32'(bus.ir_valid), 32'h1);

      // Upper target bits truncate: 0x1010 >> 2 = 0x404 -> 0x004.
      bus.redirect        = 1'b1;
      bus.redirect_target = 32'h0000_1010;
      tick();
      check("trunc_pc", 32'(bus.pc_out), 32'h4);
      bus.redirect = 1'b0;

      // Wrap from 1023 to 0.
      bus.redirect        = 1'b1;
      bus.redirect_target = 32'h0000_0FFC;
      tick();
      check("wrap_pre_pc", 32'(bus.pc_out), 32'h3FF);
      bus.redirect = 1'b0;
      mem[2] = 32'h0;
      tick();
      check("wrap_pc", 32'(bus.pc_out), 32'h0);
      check("wrap_irpc", 32'(bus.ir_pc), 32'h3FF);
      check("wrap_ir", bus.ir_out, 32'hA000_03FF);
      tick();
      tick();
      check("pre_zero_pc", 32'(bus.pc_out), 32'h2);
      tick();
`ifdef FETCH_HALT_DETECT_EN
      check("zero_hlt", 32'(bus.halted), 32'h1);
      check("zero_pc", 32'(bus.pc_out), 32'h2);
      check("zero_vld", 32'(bus.ir_valid), 32'h0);
`else
      check("zero_hlt", 32'(bus.halted), 32'h0);
      check("zero_ir", bus.ir_out, 32'h0);
      check("zero_irpc", 32'(bus.ir_pc), 32'h2);
      check("zero_pc", 32'(bus.pc_out), 32'h3);
      check("zero_vld", 32'(bus.ir_valid), 32'h1);
`endif

      // Reset mid-cycle with a redirect pending.
      bus.redirect        = 1'b1;
      bus.redirect_target = 32'h40;
      #2 rst = 1'b1;
      #1 check_reset_state("rst_mid");
      tick();
      rst       = 1'b0;
      bus.stall = 1'b1;

      // Redirect and stall in BOOT are ignored.
      tick();
      check("bootign_pc", 32'(bus.pc_out), 32'h0);
      check("bootign_vld", 32'(bus.ir_valid), 32'h0);
      bus.redirect = 1'b0;
      bus.stall    = 1'b0;
      tick();
      check("refetch_ir", bus.ir_out, 32'h0010_0093);
      check("refetch_pc", 32'(bus.pc_out), 32'h1);

      // Misaligned redirect traps into HALT.
      bus.redirect        = 1'b1;
      bus.redirect_target = 32'h22;
      tick();
      check("mis_err", 32'(bus.misalign_err), 32'h1);
      check("mis_hlt", 32'(bus.halted), 32'h1);
      check("mis_vld", 32'(bus.ir_valid), 32'h0);
      check("mis_pc", 32'(bus.pc_out), 32'h1);
      bus.redirect_target = 32'h0;
      tick();
      check("halt_pc", 32'(bus.pc_out), 32'h1);
      check("halt_ir", bus.ir_out, 32'h0010_0093);
      check("halt_hlt", 32'(bus.halted), 32'h1);
      bus.redirect = 1'b0;
      tick();
      check("halt_pc2", 32'(bus.pc_out), 32'h1);
      check("halt_vld2", 32'(bus.ir_valid), 32'h0);

      // Only reset leaves HALT.
      #2 rst = 1'b1;
      #1 check_reset_state("rst_halt");
      tick();
      rst = 1'b0;
      tick();
      tick();
      check("post_ir", bus.ir_out, 32'h0010_0093);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
